memory_access: RTL and testbench

Fourth pipeline stage: takes the registered ALU result, store data, destination register and control bits from the execute stage, performs the data-memory load or store against an internal word-addressed RAM with a configurable number of wait states, and loads the MEM/WB pipeline register. Its MEM/WB outputs feed the register-file write port and the execute stage's forwarding inputs. While a multi-cycle access is in flight it raises `stall` to freeze the upstream stages.

---
 rtl/memory_access_if.sv | 31 +++
 rtl/memory_access.sv | 155 +++++++++++++++
 tb/tb_memory_access.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_if.sv
//------------------------------------------------------------------------------
// memory_access_if : execute-to-memory stage operands and MEM/WB results
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface memory_access_if;
  logic [1:0]  writeBackControlIn;
  logic [1:0]  memAccessControlIn;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [4:0]  rdIn;
  logic        memWbRegWrite;
  logic [4:0]  memWbRd;
  logic [31:0] memWbData;
  logic        stall;
  logic        alignmentError;

  // master is the upstream (execute) side; slave is the memory stage
  modport master (
    output writeBackControlIn, memAccessControlIn, address, writeData, rdIn,
    input  memWbRegWrite, memWbRd, memWbData, stall, alignmentError
  );

  modport slave (
    input  writeBackControlIn, memAccessControlIn, address, writeData, rdIn,
    output memWbRegWrite, memWbRd, memWbData, stall, alignmentError
  );
endinterface

`default_nettype wire

// File: rtl/memory_access.sv
//------------------------------------------------------------------------------
// memory_access : pipeline memory stage with word RAM, wait states, MEM/WB reg
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module memory_access #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            resetN,
  memory_access_if.slave  bus
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state;
  logic [2:0]  wait_count;
  logic        lat_reg_write;
  logic        lat_mem_to_reg;
  logic        lat_mem_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [4:0]  lat_rd;

  logic [31:0] ram [DEPTH];

  logic                  mem_op_in;
  logic                  misaligned_in;
  logic                  acc_reg_write;
  logic                  acc_mem_to_reg;
  logic                  acc_mem_write;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [4:0]            acc_rd;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31:0]           rd_word;
  logic [31:0]           result_data;
  logic                  complete;
  logic                  do_store;

  assign mem_op_in     = |bus.memAccessControlIn;
  assign misaligned_in = mem_op_in && (bus.address[1:0] != 2'b00);

  // In BUSY the access runs from the latched copy; upstream inputs are ignored
  always_comb begin
    acc_reg_write  = bus.writeBackControlIn[1];
    acc_mem_to_reg = bus.writeBackControlIn[0];
    acc_mem_write  = bus.memAccessControlIn[0];
    acc_addr       = bus.address;
    acc_wdata      = bus.writeData;
    acc_rd         = bus.rdIn;
    if (state == BUSY) begin
      acc_reg_write  = lat_reg_write;
      acc_mem_to_reg = lat_mem_to_reg;
      acc_mem_write  = lat_mem_write;
      acc_addr       = lat_addr;
      acc_wdata      = lat_wdata;
      acc_rd         = lat_rd;
    end
  end

  assign acc_idx     = acc_addr[ADDR_WIDTH+1:2];
  assign rd_word     = ram[acc_idx];
  assign result_data = acc_mem_to_reg ? rd_word : acc_addr;

  assign complete = (state == BUSY) ? (wait_count == 3'd1)
                                    : (mem_op_in && !misaligned_in && (WAIT_STATES == 0));
  // Gating with resetN keeps an abandoned or reset-time store out of the RAM
  assign do_store = resetN && complete && acc_mem_write;

  always_ff @(negedge clk) begin
    if (do_store) begin
      ram[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(negedge clk or negedge resetN) begin
    if (!resetN) begin
      state              <= IDLE;
      wait_count         <= 3'd0;
      lat_reg_write      <= 1'b0;
      lat_mem_to_reg     <= 1'b0;
      lat_mem_write      <= 1'b0;
      lat_addr           <= 32'd0;
      lat_wdata          <= 32'd0;
      lat_rd             <= 5'd0;
      bus.memWbRegWrite  <= 1'b0;
      bus.memWbRd        <= 5'd0;
      bus.memWbData      <= 32'd0;
      bus.stall          <= 1'b0;
      bus.alignmentError <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (misaligned_in) begin
            bus.memWbRegWrite  <= 1'b0;
            bus.memWbRd        <= 5'd0;
            bus.memWbData      <= 32'd0;
            bus.alignmentError <= 1'b1;
          end else if (mem_op_in) begin
            if (WAIT_STATES == 0) begin
              bus.memWbRegWrite <= acc_reg_write;
              bus.memWbRd       <= acc_rd;
              bus.memWbData     <= result_data;
            end else begin
              lat_reg_write     <= bus.writeBackControlIn[1];
              lat_mem_to_reg    <= bus.writeBackControlIn[0];
              lat_mem_write     <= bus.memAccessControlIn[0];
              lat_addr          <= bus.address;
              lat_wdata         <= bus.writeData;
              lat_rd            <= bus.rdIn;
              wait_count        <= WAIT_INIT;
              bus.stall         <= 1'b1;
              state             <= BUSY;
              bus.memWbRegWrite <= 1'b0;
              bus.memWbRd       <= 5'd0;
              bus.memWbData     <= 32'd0;
            end
          end else begin
            bus.memWbRegWrite <= bus.writeBackControlIn[1];
            bus.memWbRd       <= bus.rdIn;
            bus.memWbData     <= bus.address;
          end
        end
        BUSY: begin
          if (wait_count > 3'd1) begin
            wait_count        <= wait_count - 3'd1;
            bus.memWbRegWrite <= 1'b0;
            bus.memWbRd       <= 5'd0;
            bus.memWbData     <= 32'd0;
          end else begin
            wait_count        <= 3'd0;
            bus.memWbRegWrite <= acc_reg_write;
            bus.memWbRd       <= acc_rd;
            bus.memWbData     <= result_data;
            bus.stall         <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memory_access.sv
//------------------------------------------------------------------------------
// tb_memory_access : three DUTs (0, 2 and 3 wait states) against a word model
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_memory_access;

  localparam int NDUT = 3;
  localparam int WSV [NDUT] = '{0, 2, 3};

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  logic [1:0]  wbc_i [NDUT];
  logic [1:0]  mac_i [NDUT];
  logic [31:0] adr_i [NDUT];
  logic [31:0] wd_i  [NDUT];
  logic [4:0]  rd_i  [NDUT];
  logic        dut_regw  [NDUT];
  logic [4:0]  dut_rd    [NDUT];
  logic [31:0] dut_data  [NDUT];
  logic        dut_stall [NDUT];
  logic        dut_aerr  [NDUT];

  memory_access_if bus [NDUT] ();

  generate
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
      assign bus[g].writeBackControlIn = wbc_i[g];
      assign bus[g].memAccessControlIn = mac_i[g];
      assign bus[g].address            = adr_i[g];
      assign bus[g].writeData          = wd_i[g];
      assign bus[g].rdIn               = rd_i[g];
      assign dut_regw[g]  = bus[g].memWbRegWrite;
      assign dut_rd[g]    = bus[g].memWbRd;
      assign dut_data[g]  = bus[g].memWbData;
      assign dut_stall[g] = bus[g].stall;
      assign dut_aerr[g]  = bus[g].alignmentError;

      memory_access #(.ADDR_WIDTH(8), .WAIT_STATES(WSV[g])) u_dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus[g].slave)
      );
    end
  endgenerate

  // Reference model: plain word array per DUT plus sticky error flag
  logic [31:0] mdl [NDUT][256];
  bit          aerr_m [NDUT];
  int tests = 0;
  int fails = 0;

  typedef struct {
    int          k;
    logic [1:0]  wbc;
    logic [1:0]  mac;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        e_regw;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_aerr;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_noop(input int k);
    wbc_i[k] = 2'b00;
    mac_i[k] = 2'b00;
    adr_i[k] = 32'd0;
    wd_i[k]  = 32'd0;
    rd_i[k]  = 5'd0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("%s d%0d regw", tag, k), 64'(dut_regw[k]), 64'd0);
      chk($sformatf("%s d%0d rd", tag, k), 64'(dut_rd[k]), 64'd0);
      chk($sformatf("%s d%0d data", tag, k), 64'(dut_data[k]), 64'd0);
      chk($sformatf("%s d%0d stall", tag, k), 64'(dut_stall[k]), 64'd0);
      chk($sformatf("%s d%0d aerr", tag, k), 64'(dut_aerr[k]), 64'd0);
    end
  endtask

  // Issue one instruction to DUT k; called just after a falling edge.
  task automatic run_op(input int k, input logic [1:0] wbc, input logic [1:0] mac,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input logic e_regw, input logic [4:0] e_rd, input logic [31:0] e_data,
                        input logic e_aerr, input string nm);
    bit mem = (mac != 2'b00);
    bit mis = mem && (addr[1:0] != 2'b00);
    int n   = (mem && !mis) ? WSV[k] : 0;
    int idx = int'((addr >> 2) & 32'hFF);
    wbc_i[k] = wbc;
    mac_i[k] = mac;
    adr_i[k] = addr;
    wd_i[k]  = wd;
    rd_i[k]  = rd;
    for (int e = 0; e <= n; e++) begin
      @(negedge clk);
      #1;
      if (e < n) begin
        chk($sformatf("%s busy%0d stall", nm, e), 64'(dut_stall[k]), 64'd1);
        chk($sformatf("%s busy%0d bubble", nm, e),
            {25'd0, dut_regw[k], dut_rd[k], dut_data[k]}, 64'd0);
        // garbage upstream while busy must not disturb the access
        wbc_i[k] = 2'($urandom);
        mac_i[k] = 2'($urandom);
        adr_i[k] = $urandom;
        wd_i[k]  = $urandom;
        rd_i[k]  = 5'($urandom);
      end else begin
        chk($sformatf("%s stall", nm), 64'(dut_stall[k]), 64'd0);
        chk($sformatf("%s regw", nm), 64'(dut_regw[k]), 64'(e_regw));
        chk($sformatf("%s rd", nm), 64'(dut_rd[k]), 64'(e_rd));
        chk($sformatf("%s data", nm), 64'(dut_data[k]), 64'(e_data));
        chk($sformatf("%s aerr", nm), 64'(dut_aerr[k]), 64'(e_aerr));
      end
    end
    set_noop(k);
    if (mem && !mis && mac[0]) mdl[k][idx] = wd;
    if (mis) aerr_m[k] = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      aerr_m[k] = 1'b0;
      set_noop(k);
      for (int w = 0; w < 256; w++) mdl[k][w] = 32'd0;
    end

    // k: 0 -> 0 wait states, 1 -> 2 wait states, 2 -> 3 wait states
    vecs[0]  = '{1, 2'b10, 2'b00, 32'h0000_1234, 32'h0,         5'd5,  1'b1, 5'd5,  32'h0000_1234, 1'b0};
    vecs[1]  = '{1, 2'b00, 2'b01, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0,  1'b0, 5'd0,  32'h0000_0010, 1'b0};
    vecs[2]  = '{1, 2'b11, 2'b10, 32'h0000_0010, 32'h0,         5'd7,  1'b1, 5'd7,  32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{0, 2'b00, 2'b01, 32'h0000_0010, 32'h0000_0055, 5'd0,  1'b0, 5'd0,  32'h0000_0010, 1'b0};
    vecs[4]  = '{0, 2'b11, 2'b10, 32'h0000_0010, 32'h0,         5'd3,  1'b1, 5'd3,  32'h0000_0055, 1'b0};
    vecs[5]  = '{0, 2'b11, 2'b10, 32'h0000_0410, 32'h0,         5'd4,  1'b1, 5'd4,  32'h0000_0055, 1'b0};
    vecs[6]  = '{0, 2'b11, 2'b10, 32'h0000_0013, 32'h0,         5'd9,  1'b0, 5'd0,  32'h0000_0000, 1'b1};
    vecs[7]  = '{0, 2'b10, 2'b00, 32'h0000_ABCD, 32'h0,         5'd2,  1'b1, 5'd2,  32'h0000_ABCD, 1'b1};
    vecs[8]  = '{0, 2'b11, 2'b11, 32'h0000_0010, 32'h0000_0077, 5'd8,  1'b1, 5'd8,  32'h0000_0055, 1'b1};
    vecs[9]  = '{0, 2'b11, 2'b10, 32'h0000_0010, 32'h0,         5'd8,  1'b1, 5'd8,  32'h0000_0077, 1'b1};
    vecs[10] = '{2, 2'b00, 2'b01, 32'h0000_0020, 32'h0,         5'd0,  1'b0, 5'd0,  32'h0000_0020, 1'b0};
    vecs[11] = '{1, 2'b00, 2'b01, 32'h0000_0020, 32'h0,         5'd0,  1'b0, 5'd0,  32'h0000_0020, 1'b0};
    vecs[12] = '{1, 2'b00, 2'b01, 32'h0000_0022, 32'h1234_5678, 5'd0,  1'b0, 5'd0,  32'h0000_0000, 1'b1};
    vecs[13] = '{1, 2'b11, 2'b10, 32'h0000_0020, 32'h0,         5'd11, 1'b1, 5'd11, 32'h0000_0000, 1'b1};

    resetN = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    resetN = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].k, vecs[i].wbc, vecs[i].mac, vecs[i].addr, vecs[i].wd, vecs[i].rd,
             vecs[i].e_regw, vecs[i].e_rd, vecs[i].e_data, vecs[i].e_aerr,
             $sformatf("vec%0d", i));
    end

    // Asynchronous reset with outputs and error flags preset
    #2 resetN = 1'b0;
    #1 check_all_zero("async_reset");
    #1 resetN = 1'b1;
    for (int k = 0; k < NDUT; k++) aerr_m[k] = 1'b0;

    // Reset during the second stall cycle of a 3-wait-state store
    wbc_i[2] = 2'b00;
    mac_i[2] = 2'b01;
    adr_i[2] = 32'h0000_0020;
    wd_i[2]  = 32'h0000_0001;
    @(negedge clk);
    #1 chk("midrst E0 stall", 64'(dut_stall[2]), 64'd1);
    @(negedge clk);
    #1 chk("midrst E1 stall", 64'(dut_stall[2]), 64'd1);
    #1 resetN = 1'b0;
    #1 chk("midrst stall drop", 64'(dut_stall[2]), 64'd0);
    check_all_zero("midrst");
    set_noop(2);
    #1 resetN = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    run_op(2, 2'b11, 2'b10, 32'h0000_0020, 32'h0, 5'd1, 1'b1, 5'd1, 32'h0, 1'b0, "midrst_reload");

    // Known-zero window for the random phase
    for (int k = 0; k < NDUT; k++) begin
      for (int w = 0; w < 8; w++) begin
        run_op(k, 2'b00, 2'b01, 32'h40 + 32'(4 * w), 32'h0, 5'd0,
               1'b0, 5'd0, 32'h40 + 32'(4 * w), aerr_m[k], $sformatf("clr d%0d w%0d", k, w));
      end
    end

    for (int i = 0; i < 150; i++) begin
      int          k    = int'($urandom_range(0, NDUT - 1));
      int          op   = int'($urandom_range(0, 9));
      logic [1:0]  wbc  = 2'($urandom);
      logic [1:0]  mac  = 2'b00;
      logic [31:0] addr = $urandom;
      logic [31:0] wd   = $urandom;
      logic [4:0]  rd   = 5'($urandom);
      logic        e_regw;
      logic [4:0]  e_rd;
      logic [31:0] e_data;
      int          idx;
      if (op >= 3) begin
        mac  = 2'($urandom_range(1, 3));
        addr = (addr & 32'hFFFF_FC00) | (32'h40 + 32'(4 * $urandom_range(0, 7)));
        if (op == 9) addr = addr | 32'($urandom_range(1, 3));
      end
      idx = int'((addr >> 2) & 32'hFF);
      if (op == 9) begin
        e_regw = 1'b0;
        e_rd   = 5'd0;
        e_data = 32'd0;
      end else if (op < 3) begin
        e_regw = wbc[1];
        e_rd   = rd;
        e_data = addr;
      end else begin
        e_regw = wbc[1];
        e_rd   = rd;
        e_data = wbc[0] ? mdl[k][idx] : addr;
      end
      run_op(k, wbc, mac, addr, wd, rd, e_regw, e_rd, e_data,
             aerr_m[k] | (op == 9), $sformatf("rnd%0d d%0d", i, k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
